// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Purpose  : Time-shares one external WIDTH-bit ALU (AND / OR / ADD / zero)
//            between two requesters. One operation is in flight at a time:
//            IDLE (arbitrate + accept) -> EXEC (ALU driven from registers,
//            result captured) -> RESP (result held until the owner accepts).
// Ports    : clk, rst_n           clock, asynchronous active-low reset
//            req_valid/req_ready  per-requester request handshake (bit i = i)
//            req_a*/req_b*/req_sel* per-requester operands and op select
//            rsp_valid/rsp_ready  per-requester response handshake
//            rsp_data/rsp_cout    captured ALU result and carry-out
//            alu_a/alu_b/alu_sel  registered operands to the shared ALU
//            alu_out/alu_cout     shared ALU result and carry-out
//            busy                 high whenever the FSM is not IDLE
// Config   : ALU_ARB_FIXED_PRIO_EN defined -> requester 0 always wins a tie
//            (no pointer). Undefined (default) -> round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [1:0]       req_sel0,
  input  logic [1:0]       req_sel1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_cout,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [1:0]       op_sel_q, op_sel_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;

  logic             grant;      // index of the winning requester
  logic             req_hs;     // request handshake this cycle

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Requester 0 wins whenever it is valid; otherwise requester 1.
  assign grant = ~req_valid[0];
`else
  logic ptr_q, ptr_d;
  // Tie goes to the pointer; a lone requester wins outright.
  assign grant = (req_valid == 2'b11) ? ptr_q : req_valid[1];
`endif

  // Gated by rst_n so req_ready also reads 00 while reset is held.
  assign req_ready = (rst_n && (state_q == ST_IDLE))
                   ? {req_valid[1] & grant, req_valid[0] & ~grant}
                   : 2'b00;
  assign req_hs    = |(req_valid & req_ready);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_sel_d    = op_sel_q;
    rsp_data_d  = rsp_data_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_valid_d = rsp_valid_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_hs) begin
          op_a_d   = grant ? req_a1   : req_a0;
          op_b_d   = grant ? req_b1   : req_b0;
          op_sel_d = grant ? req_sel1 : req_sel0;
          owner_d  = grant;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_data_d  = alu_out;
        rsp_cout_d  = alu_cout;
        rsp_valid_d = owner_q ? 2'b10 : 2'b01;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        // Only the owner's ready bit matters; the other bit is ignored.
        if (rsp_ready[owner_q]) begin
          rsp_valid_d = 2'b00;
          state_d     = ST_IDLE;
`ifndef ALU_ARB_FIXED_PRIO_EN
          ptr_d       = ~owner_q;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_sel_q    <= 2'b00;
      rsp_data_q  <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_valid_q <= 2'b00;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_sel_q    <= op_sel_d;
      rsp_data_q  <= rsp_data_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_valid_q <= rsp_valid_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  // ALU operands come straight from the operand registers, so they hold
  // their last value outside EXEC.
  assign alu_a     = op_a_q;
  assign alu_b     = op_b_q;
  assign alu_sel   = op_sel_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_valid = rsp_valid_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arbiter
// Purpose  : Self-checking bench for alu_share_arbiter: reset values, a
//            table of single operations, tie alternation, response
//            backpressure, reset during EXEC, and a randomized run checked
//            against a transaction-level reference model.
// Config   : honours ALU_ARB_FIXED_PRIO_EN for expected grants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req_valid = 2'b00;
  logic [1:0]   req_ready;
  logic [W-1:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic [1:0]   req_sel0 = 2'b00, req_sel1 = 2'b00;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready = 2'b00;
  logic [W-1:0] rsp_data;
  logic         rsp_cout;
  logic [W-1:0] alu_a, alu_b, alu_out;
  logic [1:0]   alu_sel;
  logic         alu_cout;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_sel0(req_sel0), .req_sel1(req_sel1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_cout(rsp_cout),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_cout(alu_cout),
    .busy(busy)
  );

  // Shared ALU. For non-ADD ops the carry is a[0]^b[0] so that carry
  // passthrough is visible at rsp_cout.
  always_comb begin
    alu_out  = '0;
    alu_cout = alu_a[0] ^ alu_b[0];
    case (alu_sel)
      2'b00: alu_out = alu_a & alu_b;
      2'b01: alu_out = alu_a | alu_b;
      2'b10: {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
      default: alu_out = '0;
    endcase
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  // Reference operation from the op table: 65-bit sum for ADD.
  function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [1:0] sel);
    logic c;
    c = a[0] ^ b[0];
    case (sel)
      2'b00:   return {c, a & b};
      2'b01:   return {c, a | b};
      2'b10:   return {1'b0, a} + {1'b0, b};
      default: return {c, {W{1'b0}}};
    endcase
  endfunction

  task automatic drive_port(input logic p, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [1:0] sel);
    if (p) begin req_a1 = a; req_b1 = b; req_sel1 = sel; end
    else   begin req_a0 = a; req_b0 = b; req_sel0 = sel; end
  endtask

  typedef struct {
    logic         port;
    logic [1:0]   sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_data;
    logic         exp_cout;
  } vec_t;

  vec_t vecs[8];

  // One isolated operation; starts and ends in the drive slot with DUT idle.
  task automatic run_vec(input vec_t v);
    drive_port(v.port, v.a, v.b, v.sel);
    req_valid = onehot(v.port);
    rsp_ready = 2'b11;
    @(negedge clk);
    chk("vec_req_ready", {62'd0, req_ready}, {62'd0, onehot(v.port)});
    step();
    req_valid = 2'b00;
    @(negedge clk);
    chk("vec_exec_busy", {63'd0, busy}, 64'd1);
    chk("vec_exec_rsp_valid", {62'd0, rsp_valid}, 64'd0);
    chk("vec_alu_a", alu_a, v.a);
    chk("vec_alu_b", alu_b, v.b);
    chk("vec_alu_sel", {62'd0, alu_sel}, {62'd0, v.sel});
    @(negedge clk);
    chk("vec_rsp_valid", {62'd0, rsp_valid}, {62'd0, onehot(v.port)});
    chk("vec_rsp_data", rsp_data, v.exp_data);
    chk("vec_rsp_cout", {63'd0, rsp_cout}, {63'd0, v.exp_cout});
    @(negedge clk);
    chk("vec_idle_rsp_valid", {62'd0, rsp_valid}, 64'd0);
    chk("vec_idle_busy", {63'd0, busy}, 64'd0);
    chk("vec_alu_a_hold", alu_a, v.a);
    step();
  endtask

  // Wait (bounded) until the DUT is idle.
  task automatic drain();
    int n;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    n = 0;
    @(negedge clk);
    while (busy && n < 20) begin @(negedge clk); n++; end
    chk("drain_timeout", {63'd0, busy}, 64'd0);
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {62'd0, req_ready}, 64'd0);
    chk({tag, "_rsp_valid"}, {62'd0, rsp_valid}, 64'd0);
    chk({tag, "_rsp_data"}, rsp_data, 64'd0);
    chk({tag, "_rsp_cout"}, {63'd0, rsp_cout}, 64'd0);
    chk({tag, "_alu_a"}, alu_a, 64'd0);
    chk({tag, "_alu_b"}, alu_b, 64'd0);
    chk({tag, "_alu_sel"}, {62'd0, alu_sel}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
  endtask

  // Random-phase model state.
  logic         pend_v[2];
  logic [W-1:0] pend_a[2], pend_b[2];
  logic [1:0]   pend_sel[2];

  initial begin
    logic [1:0] exp_g;
    int n;
    logic       m_inflight, m_owner, m_prio, g;
    int         m_acc, cyc;
    logic [W:0] m_res;
    logic [W-1:0] m_a, m_b;
    logic [1:0] m_sel, exp_rdy, exp_rv;

    vecs[0] = '{1'b0, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1};
    vecs[1] = '{1'b1, 2'b10, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b0};
    vecs[2] = '{1'b0, 2'b00, 64'hF0, 64'h3C, 64'h30, 1'b0};
    vecs[3] = '{1'b1, 2'b01, 64'h1, 64'h2, 64'h3, 1'b1};
    vecs[4] = '{1'b0, 2'b11, 64'hAAAA, 64'hAAAA, 64'd0, 1'b0};
    vecs[5] = '{1'b1, 2'b11, 64'h1, 64'h0, 64'd0, 1'b1};
    vecs[6] = '{1'b0, 2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 1'b1};
    vecs[7] = '{1'b1, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF,
                64'h0123_4567_89AB_CDEF, 1'b0};

    // ---- reset values, including req_ready held low under reset ----
    req_valid = 2'b11;
    #12;
    check_reset_outputs("rst");
    req_valid = 2'b00;
    step();
    rst_n = 1'b1;
    step();

    // ---- single-operation table (last entry on port 1 -> pointer 0) ----
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // ---- both valid continuously: alternating grants ----
    drive_port(1'b0, 64'hF0, 64'h3C, 2'b00);
    drive_port(1'b1, 64'hF0, 64'h0F, 2'b01);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_g = 2'b01;
`else
      exp_g = onehot(k[0]);
`endif
      n = 0;
      @(negedge clk);
      while (req_ready == 2'b00 && n < 10) begin @(negedge clk); n++; end
      chk("alt_grant", {62'd0, req_ready}, {62'd0, exp_g});
      @(negedge clk);
      chk("alt_exec_ready", {62'd0, req_ready}, 64'd0);
      @(negedge clk);
      chk("alt_rsp_valid", {62'd0, rsp_valid}, {62'd0, exp_g});
      chk("alt_rsp_data", rsp_data, exp_g[1] ? 64'hFF : 64'h30);
      chk("alt_resp_ready", {62'd0, req_ready}, 64'd0);
    end
    step();
    drain();

    // ---- response backpressure on port 1 ----
    drive_port(1'b1, 64'd5, 64'd7, 2'b10);
    req_valid = 2'b10;
    rsp_ready = 2'b01;            // non-owner bit high must be ignored
    @(negedge clk);
    chk("bp_grant", {62'd0, req_ready}, 64'd2);
    step();
    drive_port(1'b0, 64'h1, 64'h1, 2'b10);
    req_valid = 2'b01;            // waits while the port-1 op is in flight
    @(negedge clk);
    chk("bp_exec_ready", {62'd0, req_ready}, 64'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_rsp_valid", {62'd0, rsp_valid}, 64'd2);
      chk("bp_rsp_data", rsp_data, 64'd12);
      chk("bp_req_ready", {62'd0, req_ready}, 64'd0);
      chk("bp_busy", {63'd0, busy}, 64'd1);
    end
    step();
    rsp_ready = 2'b10;
    @(negedge clk);
    chk("bp_hs_rsp_valid", {62'd0, rsp_valid}, 64'd2);
    chk("bp_hs_req_ready", {62'd0, req_ready}, 64'd0);
    @(negedge clk);
    chk("bp_idle_busy", {63'd0, busy}, 64'd0);
    chk("bp_idle_rsp_valid", {62'd0, rsp_valid}, 64'd0);
    chk("bp_idle_grant", {62'd0, req_ready}, 64'd1);
    step();
    drain();

    // ---- reset during EXEC; pointer is 1 beforehand ----
    run_vec(vecs[2]);             // port 0 completes -> pointer 1
    drive_port(1'b1, 64'h10, 64'h20, 2'b10);
    req_valid = 2'b10;
    @(negedge clk);
    chk("rx_grant", {62'd0, req_ready}, 64'd2);
    step();                       // now in EXEC
    req_valid = 2'b11;
    chk("rx_busy_pre", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rx");
    req_valid = 2'b00;
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rx_no_rsp", {62'd0, rsp_valid}, 64'd0);
      chk("rx_idle", {63'd0, busy}, 64'd0);
    end
    step();
    drive_port(1'b0, 64'h3, 64'h4, 2'b10);
    req_valid = 2'b11;
    @(negedge clk);
    chk("rx_ptr_zero", {62'd0, req_ready}, 64'd1);
    step();
    drain();

    // ---- randomized run against the transaction model ----
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    pend_v[0] = 1'b0; pend_v[1] = 1'b0;
    m_inflight = 1'b0; m_owner = 1'b0; m_prio = 1'b0; m_acc = 0; cyc = 0;
    m_res = '0; m_a = '0; m_b = '0; m_sel = 2'b00;
    for (int t = 0; t < 3000; t++) begin
      if (t != 0) step();
      for (int i = 0; i < 2; i++) begin
        if (!pend_v[i] && $urandom_range(0, 2) != 0) begin
          pend_v[i]   = 1'b1;
          pend_a[i]   = ($urandom_range(0, 3) == 0) ? {W{1'b1}} : {$urandom, $urandom};
          pend_b[i]   = ($urandom_range(0, 3) == 0) ? 64'd1 : {$urandom, $urandom};
          pend_sel[i] = 2'($urandom_range(0, 3));
        end
      end
      drive_port(1'b0, pend_a[0], pend_b[0], pend_sel[0]);
      drive_port(1'b1, pend_a[1], pend_b[1], pend_sel[1]);
      req_valid = {pend_v[1], pend_v[0]};
      rsp_ready = 2'($urandom_range(0, 3));
      @(negedge clk);
      cyc++;
      exp_rdy = 2'b00;
      g = 1'b0;
      if (!m_inflight && (pend_v[0] || pend_v[1])) begin
        if (pend_v[0] && pend_v[1]) g = m_prio;
        else                        g = pend_v[1];
        exp_rdy = onehot(g);
      end
      exp_rv = (m_inflight && cyc >= m_acc + 2) ? onehot(m_owner) : 2'b00;
      chk("rnd_req_ready", {62'd0, req_ready}, {62'd0, exp_rdy});
      chk("rnd_busy", {63'd0, busy}, {63'd0, m_inflight});
      chk("rnd_rsp_valid", {62'd0, rsp_valid}, {62'd0, exp_rv});
      if (m_inflight && cyc == m_acc + 1) begin
        chk("rnd_alu_a", alu_a, m_a);
        chk("rnd_alu_b", alu_b, m_b);
        chk("rnd_alu_sel", {62'd0, alu_sel}, {62'd0, m_sel});
      end
      if (exp_rv != 2'b00) begin
        chk("rnd_rsp_data", rsp_data, m_res[W-1:0]);
        chk("rnd_rsp_cout", {63'd0, rsp_cout}, {63'd0, m_res[W]});
      end
      if (exp_rdy != 2'b00) begin
        m_inflight = 1'b1;
        m_acc      = cyc;
        m_owner    = g;
        m_a        = pend_a[g];
        m_b        = pend_b[g];
        m_sel      = pend_sel[g];
        m_res      = ref_op(m_a, m_b, m_sel);
        pend_v[g]  = 1'b0;
      end else if (exp_rv != 2'b00 && rsp_ready[m_owner]) begin
        m_inflight = 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
        m_prio     = ~m_owner;
`endif
      end
    end
    step();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
